// File: rtl/cap_pkg.sv
// Shared state type and trigger-mode encodings for the capture controller.
package cap_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PRE,
    POST,
    DONE,
    DUMP
  } cap_state_t;

  localparam logic [1:0]  TRIG_OFF  = 2'b00;
  localparam logic [1:0]  TRIG_NORM = 2'b01;
  localparam int unsigned TRIG_AUTO = 1;

endpackage

// File: rtl/cap_decim.sv
// Sample-strobe decimator: passes one strobe in every 2^dec_pwr as keep.
module cap_decim
  import cap_pkg::*;
#(
  parameter int unsigned DEC_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             smpl_en,
  input  logic [DEC_W-1:0] dec_pwr,
  input  logic             clr,
  output logic             keep
);

  localparam int unsigned CNT_W = 2 ** DEC_W;

  logic [CNT_W-1:0] dec_cnt_q, dec_cnt_d;
  logic [CNT_W-1:0] reload;

  always_comb begin
    reload    = (CNT_W'(1) << dec_pwr) - CNT_W'(1);
    keep      = smpl_en && (dec_cnt_q == '0);
    dec_cnt_d = dec_cnt_q;
    if (clr) begin
      dec_cnt_d = '0;
    end else if (keep) begin
      dec_cnt_d = reload;
    end else if (smpl_en) begin
      dec_cnt_d = dec_cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dec_cnt_q <= '0;
    end else begin
      dec_cnt_q <= dec_cnt_d;
    end
  end

endmodule

// File: rtl/capture_ctrl_p.sv
// Capture controller: circular sample-RAM writer with pre/post trigger and dump readout.
// Optional build macro CAP_AUTO_TIMEOUT_EN adds a scope-style auto trigger timeout.
module capture_ctrl_p
  import cap_pkg::*;
#(
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned DEC_W  = 4,
  parameter int unsigned TO_W   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              smpl_en,
  input  logic              trigger,
  input  logic [1:0]        trig_type,
  input  logic [ADDR_W-1:0] trig_pos,
  input  logic [DEC_W-1:0]  dec_pwr,
  input  logic              capture_done,
  output logic              set_capture_done,
  output logic              armed,
  output logic              busy,
  output logic [ADDR_W-1:0] trig_addr,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic              start_dump,
  input  logic              dump_rdy,
  output logic              send_dump,
  output logic              dump_finished
);

  localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

  cap_state_t state_q, state_d;

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W-1:0] pre_cnt_q, pre_cnt_d;
  logic [ADDR_W-1:0] post_cnt_q, post_cnt_d;
  logic [ADDR_W-1:0] trig_addr_q, trig_addr_d;
  logic [ADDR_W-1:0] trace_end_q, trace_end_d;
  logic [ADDR_W-1:0] beats_q, beats_d;
  logic              armed_q, armed_d;
  logic              send_dump_q, send_dump_d;
  logic              dump_fin_q, dump_fin_d;

  logic              keep;
  logic              decim_clr;
  logic              trig_off;
  logic              fire;
  logic              timeout_hit;
  logic [ADDR_W-1:0] arm_thr;
  logic [ADDR_W-1:0] post_nxt;

  cap_decim #(
    .DEC_W(DEC_W)
  ) u_decim (
    .clk    (clk),
    .rst_n  (rst_n),
    .smpl_en(smpl_en),
    .dec_pwr(dec_pwr),
    .clr    (decim_clr),
    .keep   (keep)
  );

`ifdef CAP_AUTO_TIMEOUT_EN
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_d;
    end
  end

  assign timeout_hit = (trig_type == TRIG_NORM) && (to_cnt_q == '1);
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_d          = state_q;
    wr_ptr_d         = wr_ptr_q;
    rd_ptr_d         = rd_ptr_q;
    pre_cnt_d        = pre_cnt_q;
    post_cnt_d       = post_cnt_q;
    trig_addr_d      = trig_addr_q;
    trace_end_d      = trace_end_q;
    beats_d          = beats_q;
    armed_d          = armed_q;
    send_dump_d      = 1'b0;
    dump_fin_d       = 1'b0;
    ram_en           = 1'b0;
    ram_we           = 1'b0;
    ram_addr         = wr_ptr_q;
    set_capture_done = 1'b0;
`ifdef CAP_AUTO_TIMEOUT_EN
    to_cnt_d         = to_cnt_q;
`endif

    decim_clr = (state_q == IDLE);
    trig_off  = (trig_type == TRIG_OFF);
    fire      = armed_q && (trigger || trig_type[TRIG_AUTO] || timeout_hit);
    // trig_pos is ADDR_W wide, so it never exceeds DEPTH-1 and needs no clamp
    arm_thr   = '1 - trig_pos;
    post_nxt  = post_cnt_q + ONE;

    unique case (state_q)
      IDLE: begin
        pre_cnt_d  = '0;
        post_cnt_d = '0;
        armed_d    = 1'b0;
`ifdef CAP_AUTO_TIMEOUT_EN
        to_cnt_d   = '0;
`endif
        if (!trig_off && !capture_done) begin
          state_d = PRE;
        end
      end

      PRE: begin
        if (trig_off) begin
          state_d = IDLE;
          armed_d = 1'b0;
        end else begin
          if (pre_cnt_q >= arm_thr) begin
            armed_d = 1'b1;
          end
          if (keep) begin
            ram_en   = 1'b1;
            ram_we   = 1'b1;
            wr_ptr_d = wr_ptr_q + ONE;
            if (fire) begin
              trig_addr_d = wr_ptr_q;
              post_cnt_d  = '0;
              state_d     = POST;
            end else begin
              if (pre_cnt_q != '1) begin
                pre_cnt_d = pre_cnt_q + ONE;
              end
`ifdef CAP_AUTO_TIMEOUT_EN
              if (armed_q && (trig_type == TRIG_NORM)) begin
                to_cnt_d = to_cnt_q + TO_W'(1);
              end
`endif
            end
          end
        end
      end

      POST: begin
        if (trig_off) begin
          state_d = IDLE;
          armed_d = 1'b0;
        end else if (trig_pos == '0) begin
          // Trigger sample alone closes the trace; no extra post write
          state_d          = DONE;
          set_capture_done = 1'b1;
          trace_end_d      = trig_addr_q;
          armed_d          = 1'b0;
        end else if (keep) begin
          ram_en     = 1'b1;
          ram_we     = 1'b1;
          wr_ptr_d   = wr_ptr_q + ONE;
          post_cnt_d = post_nxt;
          if (post_nxt == trig_pos) begin
            state_d          = DONE;
            set_capture_done = 1'b1;
            trace_end_d      = wr_ptr_q;
            armed_d          = 1'b0;
          end
        end
      end

      DONE: begin
        if (!capture_done) begin
          state_d = IDLE;
        end else if (start_dump) begin
          state_d  = DUMP;
          rd_ptr_d = trace_end_q + ONE;
          beats_d  = '0;
        end
      end

      DUMP: begin
        if (dump_rdy) begin
          ram_en      = 1'b1;
          ram_addr    = rd_ptr_q;
          send_dump_d = 1'b1;
          rd_ptr_d    = rd_ptr_q + ONE;
          beats_d     = beats_q + ONE;
          if (beats_q == '1) begin
            state_d    = DONE;
            dump_fin_d = 1'b1;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      pre_cnt_q   <= '0;
      post_cnt_q  <= '0;
      trig_addr_q <= '0;
      trace_end_q <= '0;
      beats_q     <= '0;
      armed_q     <= 1'b0;
      send_dump_q <= 1'b0;
      dump_fin_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      pre_cnt_q   <= pre_cnt_d;
      post_cnt_q  <= post_cnt_d;
      trig_addr_q <= trig_addr_d;
      trace_end_q <= trace_end_d;
      beats_q     <= beats_d;
      armed_q     <= armed_d;
      send_dump_q <= send_dump_d;
      dump_fin_q  <= dump_fin_d;
    end
  end

  assign armed         = armed_q;
  assign busy          = (state_q != IDLE);
  assign trig_addr     = trig_addr_q;
  assign send_dump     = send_dump_q;
  assign dump_finished = dump_fin_q;

endmodule
